sseg_scan_ctrl: RTL
===================

// Module: sseg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-anode/cathode 7-seg display.
//  - Holds a shadow copy of N BCDnumber_t digits and presents one digit at a time on hex_o.
//  - hex_o feeds the BCD-to-7seg decoder; an_o drives the digit enables.
//  - Dead time between digits suppresses ghosting; digit updates are frame-synchronous.
// PARAMETERS
//  N_DIGITS      4      number of digits; index 0 = least significant (rightmost)
//  ON_CYCLES     12500  clk cycles an enable is asserted per digit slot (>=1)
//  BLANK_CYCLES  500    clk cycles all enables are off before each slot (>=1)
//  AN_ACTIVE_LOW 1      1: an_o active-low; 0: active-high
// PORTS
//  clk           in   1            system clock, rising edge
//  rst_n         in   1            synchronous reset, active-low
//  en_i          in   1            scan enable
//  digits_i      in   N_DIGITS*5   digitos_pkg BCDnumber_t array {dp,digito} per digit
//  update_req_i  in   1            request to load digits_i into shadow; held until ack
//  update_ack_o  out  1            1-cycle pulse; digits_i sampled on this cycle
//  hex_o         out  5            BCDnumber_t of current digit, to decoder
//  an_o          out  N_DIGITS     one-hot digit enable (polarity per AN_ACTIVE_LOW)
//  frame_start_o out  1            1-cycle pulse when digit 0 slot begins (BLANK, idx 0)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE, idx=0, shadow=0, hex_o=0, an_o=all inactive,
//    update_ack_o=0, frame_start_o=0, counters=0.
//  All outputs registered. States: IDLE, BLANK, SHOW.
//  IDLE: an_o inactive; en_i=1 -> BLANK, idx=0, frame_start_o=1 that edge.
//  BLANK: an_o inactive, hex_o=shadow[idx]; after BLANK_CYCLES cycles -> SHOW.
//  SHOW: an_o[idx] active, others inactive, hex_o=shadow[idx]; after ON_CYCLES -> BLANK,
//    idx = (idx==N_DIGITS-1) ? 0 : idx+1; wrap to 0 pulses frame_start_o.
//  hex_o changes only on entry to BLANK, so decoder output is stable before enable.
//  Slot period = BLANK_CYCLES+ON_CYCLES; frame = N_DIGITS*slot period.
//  en_i=0 in BLANK/SHOW: next edge -> IDLE, an_o inactive, idx=0; counters cleared.
//  Update handshake:
//   - update_req_i=1 is latched as pending; ack issued on the edge that enters BLANK
//     with idx=0 (same cycle as frame_start_o), shadow <= digits_i in that edge.
//   - In IDLE, pending req acked on next edge (no frame wait).
//   - req rising on the exact frame-boundary edge: acked on that edge.
//   - Requester drops req after ack; req still high 1 cycle after ack = new request.
//   - en_i drop with req pending: pending kept, acked in IDLE next edge.
//  Reset mid-frame aborts scan and clears pending request.
// CONFIGURATION
//  LZ_BLANK_EN defined: leading-zero suppression. During SHOW of idx k>0, an_o stays
//    inactive if shadow[j].digito==0 and shadow[j].dp==0 for all j>=k. Digit 0 always
//    shown. Timing, hex_o and frame_start_o unchanged.
//  LZ_BLANK_EN undefined: every digit slot asserts its enable.
// TESTING (sim params N_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2, AN_ACTIVE_LOW=1)
//  1 reset: rst_n=0 2 cycles, en_i=1 -> an_o=4'b1111, hex_o=0, ack/frame_start=0.
//  2 scan: shadow {3,2,1,0}, en_i=1 -> an_o 1111 x2, 1110 x4, 1111 x2, 1101 x4, ...;
//    hex_o digito=0,1,2,3 per slot; frame_start_o every 24 cycles.
//  3 update: req mid-frame with digits_i=20'h4_3_2_1 -> ack only at next frame_start_o,
//    next frame hex_o digito=1,2,3,4; req held 3 extra cycles after ack -> 2nd ack next frame.
//  4 disable: en_i=0 during SHOW idx 2 -> next edge an_o=1111, state IDLE; re-enable
//    restarts at idx 0 with frame_start_o pulse.
//  5 IDLE update: en_i=0, req=1 -> ack 1 cycle later, shadow loaded.
//  6 LZ_BLANK_EN: shadow {0,0,5,0} -> an_o 1110,1101 asserted; idx 2,3 slots stay 1111;
//    shadow all 0 -> only an_o=1110 asserted.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed N-digit 7-seg scanner with dead time and frame-synchronous shadow updates; define LZ_BLANK_EN for leading-zero blanking
module sseg_scan_ctrl #(
  parameter int N_DIGITS      = 4,
  parameter int ON_CYCLES     = 12500,
  parameter int BLANK_CYCLES  = 500,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [N_DIGITS*5-1:0] digits_i,
  input  logic                  update_req_i,
  output logic                  update_ack_o,
  output logic [4:0]            hex_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_start_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2((ON_CYCLES > BLANK_CYCLES ? ON_CYCLES : BLANK_CYCLES) + 1);
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};
  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [N_DIGITS*5-1:0] shadow_q, shadow_d;
  logic                  pend_q, pend_d;
  logic [4:0]            hex_q, hex_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  ack_q, ack_d;
  logic                  fs_q, fs_d;
  logic                  req, last, bdone, sdone, lit;
  assign req   = pend_q | update_req_i;
  assign last  = idx_q == IW'(N_DIGITS - 1);
  assign bdone = cnt_q == CW'(BLANK_CYCLES - 1);
  assign sdone = cnt_q == CW'(ON_CYCLES - 1);
`ifdef LZ_BLANK_EN
  logic [N_DIGITS:0] nz;
  always_comb begin
    nz[N_DIGITS] = 1'b0;
    for (int k = N_DIGITS - 1; k >= 0; k--) nz[k] = nz[k+1] | (|shadow_q[5*k +: 5]);
  end
  assign lit = (idx_q == '0) | nz[idx_q];
`else
  assign lit = 1'b1;
`endif
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = '0;
    shadow_d = shadow_q;
    hex_d    = hex_q;
    an_d     = an_q;
    ack_d    = 1'b0;
    fs_d     = 1'b0;
    if (state_q == IDLE) begin
      ack_d   = req;
      state_d = en_i ? BLANK : IDLE;
      idx_d   = '0;
      fs_d    = en_i;
      an_d    = AN_OFF;
    end else if (!en_i) begin
      state_d = IDLE;
      idx_d   = '0;
      an_d    = AN_OFF;
    end else if (state_q == BLANK) begin
      cnt_d   = bdone ? '0 : cnt_q + 1'b1;
      state_d = bdone ? SHOW : BLANK;
      an_d    = (bdone && lit) ? AN_OFF ^ (N_DIGITS'(1) << idx_q) : AN_OFF;
    end else begin
      cnt_d   = sdone ? '0 : cnt_q + 1'b1;
      state_d = sdone ? BLANK : SHOW;
      an_d    = sdone ? AN_OFF : an_q;
      idx_d   = sdone ? (last ? '0 : idx_q + 1'b1) : idx_q;
      fs_d    = sdone & last;
      ack_d   = sdone & last & req;
    end
    if (ack_d) shadow_d = digits_i;
    if (state_d == BLANK && state_q != BLANK) hex_d = shadow_d[5*int'(idx_d) +: 5];
    pend_d = req & ~ack_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      hex_q    <= '0;
      an_q     <= AN_OFF;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      hex_q    <= hex_d;
      an_q     <= an_d;
      ack_q    <= ack_d;
      fs_q     <= fs_d;
    end
  end
  assign update_ack_o  = ack_q;
  assign hex_o         = hex_q;
  assign an_o          = an_q;
  assign frame_start_o = fs_q;
endmodule
